// File: rtl/rat_io_responder.sv
// Port-mapped I/O responder for the RAT MCU: output latches, read mux,
// prescaled interval timer, button edge detect and interrupt pulse FSM.
module rat_io_responder #(
  parameter int PRESCALE         = 1000,
  parameter int INT_PULSE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INTV,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int PC_W = $clog2(INT_PULSE_CYCLES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(INT_PULSE_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_ARMED} state_t;

  logic [7:0]      r_leds, r_sseg, r_reload, r_count;
  logic [PS_W-1:0] r_ps;
  logic [1:0]      r_int_en, r_pending;
  logic [3:0]      r_btn_s1, r_btn_s2, r_btn_s3;
  logic [PC_W-1:0] r_pcnt;
  state_t          r_state;

  logic            w_wr_led, w_wr_sseg, w_wr_reload, w_wr_en, w_wr_clr;
  logic            w_tick, w_timer_evt, w_req;
  logic [3:0]      w_btn_rise;
  logic [1:0]      w_set, w_clr;
  logic [PC_W-1:0] w_pcnt_nxt;
  state_t          w_state_nxt;

  assign w_wr_led    = IO_STRB && (PORT_ID == 8'h40);
  assign w_wr_sseg   = IO_STRB && (PORT_ID == 8'h41);
  assign w_wr_reload = IO_STRB && (PORT_ID == 8'h42);
  assign w_wr_en     = IO_STRB && (PORT_ID == 8'h43);
  assign w_wr_clr    = IO_STRB && (PORT_ID == 8'h44);

  // A reload write restarts the period, so a coincident tick is discarded.
  assign w_tick      = (r_reload != 8'd0) && (r_ps == PS_LAST) && !w_wr_reload;
  assign w_timer_evt = w_tick && (r_count == 8'd1);
  assign w_btn_rise  = r_btn_s2 & ~r_btn_s3;
  assign w_set       = {|w_btn_rise, w_timer_evt};
  assign w_clr       = w_wr_clr ? OUT_PORT[1:0] : 2'b00;
  assign w_req       = |(r_pending & r_int_en);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_leds    <= '0;
      r_sseg    <= '0;
      r_int_en  <= '0;
      r_pending <= '0;
      r_btn_s1  <= '0;
      r_btn_s2  <= '0;
      r_btn_s3  <= '0;
    end else begin
      if (w_wr_led)  r_leds   <= OUT_PORT;
      if (w_wr_sseg) r_sseg   <= OUT_PORT;
      if (w_wr_en)   r_int_en <= OUT_PORT[1:0];
      // Set after clear so a same-edge event is never lost.
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_btn_s1  <= BUTTONS;
      r_btn_s2  <= r_btn_s1;
      r_btn_s3  <= r_btn_s2;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_reload <= '0;
      r_count  <= '0;
      r_ps     <= '0;
    end else if (w_wr_reload) begin
      r_reload <= OUT_PORT;
      r_count  <= OUT_PORT;
      r_ps     <= '0;
    end else if (r_reload != 8'd0) begin
      if (r_ps == PS_LAST) begin
        r_ps    <= '0;
        r_count <= (r_count == 8'd1) ? r_reload : r_count - 8'd1;
      end else begin
        r_ps <= r_ps + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
    end
  end

  // ARMED waits for the ISR to drop req so one event yields one pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_PULSE;
          w_pcnt_nxt  = PC_W'(1);
        end
      end
      ST_PULSE: begin
        if (r_pcnt == PC_LAST) w_state_nxt = ST_ARMED;
        else                   w_pcnt_nxt  = r_pcnt + PC_W'(1);
      end
      ST_ARMED: begin
        if (!w_req) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      8'h20:   IN_PORT = SWITCHES;
      8'h21:   IN_PORT = {4'b0000, r_btn_s2};
      8'h22:   IN_PORT = {6'b000000, r_pending};
      8'h23:   IN_PORT = r_count;
      8'h24:   IN_PORT = {6'b000000, r_int_en};
      default: IN_PORT = 8'h00;
    endcase
  end

  assign INTV     = (r_state == ST_PULSE);
  assign LEDS     = r_leds;
  assign SSEG_VAL = r_sseg;

endmodule

// File: tb/tb_rat_io_responder.sv
// Bench for rat_io_responder: directed port accesses with direct read checks,
// and a scoreboard of expected INTV pulses consumed by an independent monitor.
`timescale 1ns/1ps
module tb_rat_io_responder;

  logic       clk = 1'b0;
  logic       RESET;
  logic [7:0] PORT_ID, OUT_PORT, IN_PORT, SWITCHES, LEDS, SSEG_VAL;
  logic       IO_STRB, INTV;
  logic [3:0] BUTTONS;

  rat_io_responder #(.PRESCALE(4), .INT_PULSE_CYCLES(4)) dut (
    .clk(clk), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INTV(INTV), .SWITCHES(SWITCHES),
    .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG_VAL(SSEG_VAL)
  );

  always #5 clk = ~clk;

  typedef struct { int start; int width; } pulse_t;
  pulse_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: measures each INTV pulse (posedge index of rise, width in cycles).
  logic   mon_prev = 1'b0;
  int     mon_start = 0;
  pulse_t mon_exp;
  always @(negedge clk) begin
    if (INTV === 1'b1 && !mon_prev) mon_start = cyc;
    if (INTV !== 1'b1 && mon_prev) begin
      if (sb_q.size() == 0) begin
        check("intv_unexpected_pulse_start", mon_start, -1);
      end else begin
        mon_exp = sb_q.pop_front();
        check("intv_pulse_start", mon_start, mon_exp.start);
        check("intv_pulse_width", cyc - mon_start, mon_exp.width);
      end
    end
    mon_prev = (INTV === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // All stimulus runs at negedge instants; k is the posedge index performing the write.
  task automatic io_write(input logic [7:0] addr, input logic [7:0] data, output int k);
    k        = cyc + 1;
    PORT_ID  = addr;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    @(negedge clk);
    IO_STRB  = 1'b0;
    PORT_ID  = 8'h00;
  endtask

  task automatic rd_check(input string name, input logic [7:0] addr, input int exp);
    PORT_ID = addr;
    #1;
    check(name, IN_PORT, exp);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int k, k2, c, c2;
    RESET = 1'b1; PORT_ID = 8'h20; OUT_PORT = 8'h00; IO_STRB = 1'b0;
    SWITCHES = 8'hA5; BUTTONS = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_intv", INTV, 0);
    RESET = 1'b0;
    @(negedge clk);
    rd_check("rd_switches", 8'h20, 8'hA5);
    check("reset_leds", LEDS, 0);
    check("reset_sseg", SSEG_VAL, 0);
    check("reset_intv_after", INTV, 0);

    io_write(8'h40, 8'h3C, k);
    check("leds_write", LEDS, 8'h3C);
    io_write(8'h41, 8'h5A, k);
    check("sseg_write", SSEG_VAL, 8'h5A);
    io_write(8'h50, 8'hFF, k);
    check("ignored_write_leds", LEDS, 8'h3C);
    check("ignored_write_sseg", SSEG_VAL, 8'h5A);
    rd_check("rd_unmapped", 8'h99, 8'h00);

    // Timer: reload 3, prescale 4 -> event 12 cycles after the reload write.
    io_write(8'h43, 8'h01, k);
    rd_check("rd_int_en", 8'h24, 8'h01);
    io_write(8'h42, 8'h03, k);
    sb_q.push_back('{start: k + 13, width: 4});
    rd_check("count_loaded", 8'h23, 8'h03);
    wait_cyc(k + 11);
    rd_check("pending_before_evt", 8'h22, 8'h00);
    rd_check("count_decremented", 8'h23, 8'h01);
    wait_cyc(k + 12);
    rd_check("pending_timer_set", 8'h22, 8'h01);
    wait_cyc(k + 19);
    check("intv_low_armed", INTV, 0);
    io_write(8'h44, 8'h01, k2);
    rd_check("pending_w1c", 8'h22, 8'h00);
    sb_q.push_back('{start: k + 25, width: 4});
    wait_cyc(k + 24);
    rd_check("pending_second_evt", 8'h22, 8'h01);
    rd_check("count_reloaded", 8'h23, 8'h03);
    wait_cyc(k + 31);
    io_write(8'h42, 8'h00, k2);
    io_write(8'h44, 8'h03, k2);
    rd_check("pending_cleared_halt", 8'h22, 8'h00);

    // Timer set and W1C on the same edge: set wins.
    io_write(8'h43, 8'h00, k);
    io_write(8'h42, 8'h01, k);
    wait_cyc(k + 5);
    rd_check("pending_reload1", 8'h22, 8'h01);
    wait_cyc(k + 7);
    io_write(8'h44, 8'h01, k2);
    check("same_edge_write_cycle", k2, k + 8);
    rd_check("pending_set_wins", 8'h22, 8'h01);
    io_write(8'h42, 8'h00, k2);
    io_write(8'h44, 8'h01, k2);
    rd_check("pending_plain_clear", 8'h22, 8'h00);

    // Button edge: pending[1] three cycles after the press.
    io_write(8'h43, 8'h02, k);
    c = cyc;
    BUTTONS = 4'b0100;
    sb_q.push_back('{start: c + 4, width: 4});
    wait_cyc(c + 2);
    rd_check("btn_sync", 8'h21, 8'h04);
    rd_check("btn_pending_early", 8'h22, 8'h00);
    wait_cyc(c + 3);
    rd_check("btn_pending_set", 8'h22, 8'h02);
    wait_cyc(c + 20);
    check("btn_held_no_repulse", INTV, 0);
    io_write(8'h44, 8'h02, k2);
    rd_check("btn_pending_clear", 8'h22, 8'h00);
    BUTTONS = 4'b0000;
    wait_cyc(cyc + 4);
    c2 = cyc;
    BUTTONS = 4'b0001;
    sb_q.push_back('{start: c2 + 4, width: 2});
    io_write(8'h42, 8'h07, k2);

    // Reset during the second pulse.
    wait_cyc(c2 + 5);
    check("intv_before_reset", INTV, 1);
    #2;
    RESET   = 1'b1;
    BUTTONS = 4'b0000;
    #1;
    check("intv_async_drop", INTV, 0);
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b0;
    check("post_reset_leds", LEDS, 0);
    check("post_reset_sseg", SSEG_VAL, 0);
    rd_check("post_reset_pending", 8'h22, 8'h00);
    rd_check("post_reset_count", 8'h23, 8'h00);
    rd_check("post_reset_int_en", 8'h24, 8'h00);
    rd_check("post_reset_btn", 8'h21, 8'h00);
    wait_cyc(cyc + 10);
    check("post_reset_intv", INTV, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rat_io_responder.md
Name: rat_io_responder

Overview:
- Port-mapped I/O responder on the far side of the RAT MCU port bus (PORT_ID, OUT_PORT, IO_STRB, IN_PORT, INTV).
- Decodes OUT/IN port addresses and holds the output latches (LEDs, 7-seg value).
- Returns switch, button, status and timer data on IN_PORT.
- Runs a prescaled interval timer and a button-edge detector, and drives the MCU interrupt line INTV through a pulse/handshake FSM.

Parameters:
- PRESCALE, 1000, clk cycles per timer tick (≥2).
- INT_PULSE_CYCLES, 4, cycles INTV is held high per interrupt (≥1).

Ports:
- clk  input  1  system clock, all state on rising edge
- RESET  input  1  asynchronous, active-high reset
- PORT_ID  input  8  port address from MCU
- OUT_PORT  input  8  write data from MCU
- IO_STRB  input  1  write strobe, one cycle per OUT instruction
- IN_PORT  output  8  read data to MCU, combinational from PORT_ID
- INTV  output  1  interrupt request to MCU
- SWITCHES  input  8  board switches, treated as quasi-static
- BUTTONS  input  4  asynchronous push buttons
- LEDS  output  8  LED latch
- SSEG_VAL  output  8  seven-segment value latch

Behaviour:
- Reset (async): LEDS=0, SSEG_VAL=0, reload=0, count=0, prescaler=0, int_en=0, pending=0, btn sync regs=0, FSM=IDLE, INTV=0.
- Write ports: on a rising edge with IO_STRB=1.
  - 0x40 LEDS←OUT_PORT.
  - 0x41 SSEG_VAL←OUT_PORT.
  - 0x42 reload←OUT_PORT, count←OUT_PORT, prescaler←0.
  - 0x43 int_en←OUT_PORT[1:0].
  - 0x44 pending←pending & ~OUT_PORT[1:0] (write-1-to-clear).
  - Other addresses are ignored. A write is visible on outputs the next cycle.
- Read ports: IN_PORT is a combinational mux on PORT_ID, independent of IO_STRB.
  - 0x20 SWITCHES.
  - 0x21 {4'b0, btn_sync}.
  - 0x22 {6'b0, pending}.
  - 0x23 count.
  - 0x24 {6'b0, int_en}.
  - Any other address returns 0x00.
- Buttons: two-flop synchronizer, then a third registered copy for edge detect. Any 0→1 on any synchronized bit sets pending[1], 3 cycles after the input edge.
- Timer:
  - reload=0 halts the timer: prescaler and count hold.
  - Otherwise the prescaler counts 0..PRESCALE-1; each wrap is a tick.
  - On a tick: if count==1, count←reload and pending[0] is set; otherwise count decrements.
  - The interrupt period is reload×PRESCALE cycles.
- Pending bits are set regardless of int_en; int_en gates only interrupt generation. Set and clear in the same cycle: set wins.
- req = |(pending & int_en).
- Interrupt FSM:
  - IDLE: if req → PULSE, INTV=1, pulse counter←1.
  - PULSE: INTV=1. When pulse counter==INT_PULSE_CYCLES → ARMED, INTV=0; otherwise the counter increments.
  - ARMED: INTV=0. When req==0 (ISR cleared the pending bits) → IDLE.
  - A new event arriving while the FSM is in ARMED does not re-pulse until req drops. A fresh event after IDLE produces a new pulse.
- Reset mid-pulse: INTV drops immediately (async).

Test Plan:
- RESET high then low; PORT_ID=0x20 with SWITCHES=0xA5 → IN_PORT=0xA5; LEDS=0, INTV=0.
- IO_STRB with PORT_ID=0x40, OUT_PORT=0x3C → LEDS=0x3C next cycle. Strobe to 0x50 → no latch changes. PORT_ID=0x99 → IN_PORT=0x00.
- PRESCALE=4, write 0x43←0x01, then 0x42←0x03 → pending[0] set 12 cycles after the write. INTV high for exactly 4 cycles, then low. Write 0x44←0x01 → FSM returns to IDLE; the next pulse comes 12 cycles after the previous set.
- int_en=0x02, BUTTONS[2] 0→1 → pending=0x02 within 3 cycles and INTV pulses. Hold the button → no second pulse. Clear, release, press again → second pulse.
- Timer event and write 0x44←0x01 on the same edge → pending[0] stays 1.
- Assert RESET during PULSE → INTV=0 immediately. After release, all latches, pending and count read 0.
